// File: rtl/cpu_run_ctrl.sv
// Run/step/breakpoint sequencer for the single-cycle CPU.
// Generates datapath reset, execute enable and a retired-instruction count.
module cpu_run_ctrl #(
  parameter int PC_W       = 7,
  parameter int CNT_W      = 16,
  parameter int RST_CYCLES = 4
) (
  input  logic             CLOCK_50,
  input  logic             rst_n,
  input  logic             run_req,
  input  logic             halt_req,
  input  logic             step_req,
  input  logic             cpu_reset_req,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  pc,
  output logic             cpu_rst,
  output logic             cpu_en,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] instr_count,
  output logic             halted_bp
);

  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_INIT = RC_W'(RST_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RESET = 2'b00,
    S_HALT  = 2'b01,
    S_RUN   = 2'b10,
    S_STEP  = 2'b11
  } state_t;

  state_t           r_state;
  logic             r_cpu_rst;
  logic [RC_W-1:0]  r_rc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_hbp;
  logic             r_skip;

  logic w_match;
  logic w_bp_hit;
  logic w_en;
  logic w_cnt_max;

  assign w_match   = bp_en & (pc == bp_addr);
  assign w_bp_hit  = w_match & ~r_skip;
  assign w_en      = ~cpu_reset_req &
                     (((r_state == S_RUN) & ~w_bp_hit) |
                      (r_state == S_STEP));
  assign w_cnt_max = &r_cnt;

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      r_state   <= S_RESET;
      r_cpu_rst <= 1'b1;
      r_rc      <= RC_INIT;
      r_cnt     <= '0;
      r_hbp     <= 1'b0;
      r_skip    <= 1'b0;
    end else begin
      if (w_en && !w_cnt_max)
        r_cnt <= r_cnt + CNT_W'(1);
      if (r_state == S_RESET) begin
        if (r_rc == '0) begin
          r_state   <= S_HALT;
          r_cpu_rst <= 1'b0;
        end else begin
          r_rc <= r_rc - RC_W'(1);
        end
      end else if (cpu_reset_req) begin
        r_state   <= S_RESET;
        r_cpu_rst <= 1'b1;
        r_rc      <= RC_INIT;
        r_cnt     <= '0;
        r_hbp     <= 1'b0;
        r_skip    <= 1'b0;
      end else begin
        unique case (r_state)
          S_HALT: begin
            unique case (1'b1)
              halt_req: ;
              run_req: begin
                r_state <= S_RUN;
                r_hbp   <= 1'b0;
                r_skip  <= w_match;
              end
              step_req: begin
                r_state <= S_STEP;
                r_hbp   <= 1'b0;
              end
              default: ;
            endcase
          end
          // Skip only shields the very first cycle of a resumed run
          S_RUN: begin
            r_skip <= 1'b0;
            if (w_bp_hit) begin
              r_state <= S_HALT;
              r_hbp   <= 1'b1;
            end else if (halt_req) begin
              r_state <= S_HALT;
            end
          end
          S_STEP:  r_state <= S_HALT;
          default: r_state <= S_HALT;
        endcase
      end
    end
  end

  assign cpu_rst     = r_cpu_rst;
  assign cpu_en      = w_en;
  assign state       = r_state;
  assign instr_count = r_cnt;
  assign halted_bp   = r_hbp;

endmodule
